// File: rtl/alarm_timer_pkg.sv
// alarm_timer_pkg: register offsets and CONTROL bit positions shared by the
// multi-channel alarm timer.
package alarm_timer_pkg;
    localparam logic [1:0] STATUS  = 2'd0;
    localparam logic [1:0] CONTROL = 2'd1;
    localparam logic [1:0] PERIOD  = 2'd2;
    localparam logic [1:0] SNAP    = 2'd3;
    // Global registers sit just above the channel banks, at 4*NUM_CH + offset
    localparam int PRESCALE_ADDR = 0;
    localparam int IRQ_PEND_ADDR = 1;
    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;
endpackage

// File: rtl/alarm_timer_chan.sv
// alarm_timer_chan: one down-counter channel with period, control, timeout
// flag and snapshot registers; START/STOP/reload act one clock after the write.
module alarm_timer_chan
    import alarm_timer_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 99999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             status_we,
    input  logic             control_we,
    input  logic             period_we,
    input  logic             snap_we,
    input  logic [CNT_W-1:0] wdata,
    output logic [3:0][31:0] rdata,
    output logic             to_masked
);
    logic [CNT_W-1:0] cnt, period, snap;
    logic ito, cont, to, run, start_p, stop_p, reload_p, ev;

    // A pending period reload suppresses the timeout it would otherwise race
    assign ev = run & tick & (cnt == '0) & ~reload_p;
    assign to_masked = to & ito;

    assign rdata[STATUS]  = 32'({run, to});
    assign rdata[CONTROL] = 32'({cont, ito});
    assign rdata[PERIOD]  = 32'(period);
    assign rdata[SNAP]    = 32'(snap);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= CNT_W'(DEFAULT_PERIOD);
            period   <= CNT_W'(DEFAULT_PERIOD);
            snap     <= '0;
            ito      <= 1'b0;
            cont     <= 1'b0;
            to       <= 1'b0;
            run      <= 1'b0;
            start_p  <= 1'b0;
            stop_p   <= 1'b0;
            reload_p <= 1'b0;
        end else begin
            if (control_we) begin
                ito  <= wdata[ITO];
                cont <= wdata[CONT];
            end
            start_p  <= control_we & wdata[START];
            stop_p   <= control_we & wdata[STOP];
            reload_p <= period_we;
            if (period_we) period <= wdata;
            if (snap_we) snap <= cnt;
            to <= ev | (to & ~status_we);
            if (reload_p) begin
                cnt <= period;
                run <= 1'b0;
            end else begin
                if (run & tick) cnt <= (cnt == '0) ? period : cnt - CNT_W'(1);
                run <= stop_p ? 1'b0 : start_p ? 1'b1 : (ev & ~cont) ? 1'b0 : run;
            end
        end
    end
endmodule

// File: rtl/alarm_timer_mc.sv
// alarm_timer_mc: NUM_CH interval timers behind a 32-bit Avalon-MM slave,
// sharing one prescaler and one level-sensitive irq.
module alarm_timer_mc
    import alarm_timer_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 99999,
    parameter int PRESC_W        = 16,
    localparam int AW            = $clog2(4*NUM_CH+2)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          irq
);
    logic                 wen, tick, presc_we, presc_reload;
    logic [PRESC_W-1:0]   prescale, presc_cnt;
    logic [NUM_CH-1:0]    pend;
    logic [3:0][31:0]     rd_v [NUM_CH];
    logic [31:0]          rmux;

    assign wen      = chipselect & ~write_n;
    assign presc_we = wen && (int'(address) == 4*NUM_CH + PRESCALE_ADDR);
    assign tick     = presc_cnt == '0;
    assign irq      = |pend;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        assign sel = wen && ((int'(address) >> 2) == c);
        alarm_timer_chan #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEFAULT_PERIOD)) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick),
            .status_we  (sel && address[1:0] == STATUS),
            .control_we (sel && address[1:0] == CONTROL),
            .period_we  (sel && address[1:0] == PERIOD),
            .snap_we    (sel && address[1:0] == SNAP),
            .wdata      (writedata[CNT_W-1:0]),
            .rdata      (rd_v[c]),
            .to_masked  (pend[c])
        );
    end

    always_comb begin
        rmux = '0;
        for (int i = 0; i < NUM_CH; i++)
            if ((int'(address) >> 2) == i) rmux = rd_v[i][address[1:0]];
        if (int'(address) == 4*NUM_CH + PRESCALE_ADDR) rmux = 32'(prescale);
        if (int'(address) == 4*NUM_CH + IRQ_PEND_ADDR) rmux = 32'(pend);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale     <= '0;
            presc_cnt    <= '0;
            presc_reload <= 1'b0;
            readdata     <= '0;
        end else begin
            presc_reload <= presc_we;
            if (presc_we) prescale <= writedata[PRESC_W-1:0];
            presc_cnt <= (presc_reload | tick) ? prescale : presc_cnt - PRESC_W'(1);
            if (chipselect & write_n) readdata <= rmux;
        end
    end
endmodule

// File: tb/tb_alarm_timer_mc.sv
// tb_alarm_timer_mc: directed register-level checks of alarm_timer_mc with
// hand-computed cycle counts and register values.
module tb_alarm_timer_mc;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    alarm_timer_mc dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge: one clk each
    task automatic wr(input int a, input logic [31:0] d);
        address = 5'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        address = 5'(a); chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic rdchk(input string tag, input int a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_irq(input int lim, output int n);
        n = 0;
        while (!irq && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, hits;
        logic [31:0] d;
        repeat (2) @(negedge clk);
        check("rst_readdata", readdata, 0);
        check("rst_irq", irq, 0);
        reset_n = 1'b1;
        rdchk("rst_period0", 2, 99999);
        rdchk("rst_status0", 0, 0);
        rdchk("rst_prescale", 16, 0);
        wr(20, 32'hFFFF_FFFF);
        rdchk("unmapped", 20, 0);
        rdchk("prescale_keep", 16, 0);

        // ch1 continuous, PERIOD=4, PRESCALE=0
        wr(6, 4);
        wr(5, 7);
        wait_irq(50, n);
        check("ch1_first_to", n, 6);
        rdchk("irq_pend", 17, 2);
        wr(4, 0);
        check("status_clr_irq", irq, 0);
        wait_irq(50, n);
        check("ch1_second_to", n, 3);
        wr(4, 0);
        wait_irq(50, n);
        check("ch1_period5", n, 4);
        wr(5, 8);
        @(negedge clk);
        wr(4, 0);
        check("ch1_stopped_irq", irq, 0);

        // ch2 PERIOD=2: STATUS write lands on the timeout edge
        wr(10, 2);
        wr(9, 7);
        wait_irq(50, n);
        check("ch2_first_to", n, 4);
        wr(8, 0);
        check("ch2_clr", irq, 0);
        @(negedge clk);
        wr(8, 0);
        check("race_irq", irq, 1);
        rdchk("race_status", 8, 3);
        wr(9, 8);
        @(negedge clk);
        wr(8, 0);
        rdchk("ch2_stop_status", 8, 0);

        // ch0 one-shot, PERIOD=3, PRESCALE=2
        wr(16, 2);
        wr(2, 3);
        wr(1, 5);
        wait_irq(100, n);
        check("oneshot_to", n, 11);
        rdchk("oneshot_status", 0, 1);
        wr(0, 0);
        hits = 0;
        repeat (30) begin
            @(negedge clk);
            if (irq) hits++;
        end
        check("oneshot_once", hits, 0);
        wr(3, 0);
        rdchk("oneshot_cnt", 3, 3);
        rdchk("oneshot_ctl", 1, 1);
        wr(16, 0);

        // START+STOP together while running
        wr(1, 6);
        @(negedge clk);
        rdchk("ss_running", 0, 2);
        wr(1, 32'hE);
        @(negedge clk);
        rdchk("ss_stopped", 0, 0);
        rdchk("ss_ctl", 1, 2);

        // PERIOD write mid-count
        wr(1, 6);
        repeat (3) @(negedge clk);
        wr(2, 7);
        @(negedge clk);
        wr(3, 0);
        rdchk("pw_cnt", 3, 7);
        rdchk("pw_status", 0, 1);
        wr(0, 0);

        // ch3 snapshot with PERIOD=1000
        wr(14, 1000);
        wr(13, 6);
        repeat (4) @(negedge clk);
        wr(15, 0);
        rdchk("snap3", 15, 997);
        rdchk("snap0_keep", 3, 7);
        rdchk("period1_keep", 6, 4);
        rdchk("snap1_zero", 7, 0);
        rdchk("snap3_hold", 15, 997);

        // asynchronous reset mid-count
        wr(5, 7);
        wait_irq(50, n);
        check("pre_reset_irq", irq, 1);
        rd(14, d);
        check("pre_reset_rd", d, 1000);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 0);
        check("async_rst_irq", irq, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rdchk("rst2_period3", 14, 99999);
        rdchk("rst2_ctl1", 5, 0);
        rdchk("rst2_snap3", 15, 0);
        rdchk("rst2_status1", 4, 0);
        rdchk("rst2_pend", 17, 0);
        rdchk("rst2_prescale", 16, 0);
        check("rst2_irq", irq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
